// File: rtl/bcd2b_seq.sv
// Sequential BCD-to-binary converter: four packed BCD digits in, 16-bit binary out.
// Processes one digit per clock with a multiply-by-ten-and-accumulate datapath.
module bcd2b_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  thousands_i,
  input  logic [3:0]  hundreds_i,
  input  logic [3:0]  tens_i,
  input  logic [3:0]  ones_i,
  output logic [15:0] binary_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_digits;
  logic [13:0] r_acc;
  logic [1:0]  r_cnt;
  logic        r_invalid;

  logic        w_start_accept;
  logic        w_last;
  logic [3:0]  w_digit;
  logic [13:0] w_acc_nxt;
  logic        w_invalid_in;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_load_result;

  function automatic logic digit_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  assign w_start_accept = (r_state == S_IDLE) && start_i;
  assign w_last         = (r_cnt == 2'd3);
  assign w_invalid_in   = digit_bad(thousands_i) | digit_bad(hundreds_i) |
                          digit_bad(tens_i)      | digit_bad(ones_i);

  // Select the digit for this step, most significant first
  always_comb begin
    w_digit = 4'd0;
    case (r_cnt)
      2'd0:    w_digit = r_digits[15:12];
      2'd1:    w_digit = r_digits[11:8];
      2'd2:    w_digit = r_digits[7:4];
      2'd3:    w_digit = r_digits[3:0];
      default: w_digit = 4'd0;
    endcase
  end

  // acc*10 as (acc<<3)+(acc<<1); wraps harmlessly when the result is discarded
  assign w_acc_nxt = {r_acc[10:0], 3'b000} + {r_acc[12:0], 1'b0} + {10'd0, w_digit};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CONV;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode, registered below so no input reaches an output combinationally
  always_comb begin
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_load_result = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_busy_nxt = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_CONV: begin
        if (w_last) begin
          w_done_nxt    = 1'b1;
          w_load_result = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_load_result = 1'b0;
      end
    endcase
  end

  // Capture operands on start, then accumulate one digit per clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_digits  <= 16'h0000;
      r_acc     <= 14'd0;
      r_cnt     <= 2'd0;
      r_invalid <= 1'b0;
    end else if (w_start_accept) begin
      r_digits  <= {thousands_i, hundreds_i, tens_i, ones_i};
      r_acc     <= 14'd0;
      r_cnt     <= 2'd0;
      r_invalid <= w_invalid_in;
    end else if (r_state == S_CONV) begin
      r_acc     <= w_acc_nxt;
      r_cnt     <= r_cnt + 2'd1;
      r_invalid <= r_invalid;
    end else begin
      r_digits  <= r_digits;
      r_acc     <= r_acc;
      r_cnt     <= r_cnt;
      r_invalid <= r_invalid;
    end
  end

  // Registered outputs; result and error only move on the done edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      binary_o <= 16'h0000;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      busy_o <= w_busy_nxt;
      done_o <= w_done_nxt;
      if (w_load_result) begin
        binary_o <= r_invalid ? 16'h0000 : {2'b00, w_acc_nxt};
        error_o  <= r_invalid;
      end else begin
        binary_o <= binary_o;
        error_o  <= error_o;
      end
    end
  end

endmodule

// File: tb/tb_bcd2b_seq.sv
// Directed self-checking bench for bcd2b_seq, ending with a full sweep of valid inputs.
module tb_bcd2b_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  thousands_i = 4'd0;
  logic [3:0]  hundreds_i = 4'd0;
  logic [3:0]  tens_i = 4'd0;
  logic [3:0]  ones_i = 4'd0;
  logic [15:0] binary_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  bcd2b_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .thousands_i (thousands_i),
    .hundreds_i  (hundreds_i),
    .tens_i      (tens_i),
    .ones_i      (ones_i),
    .binary_o    (binary_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present digits with a one-cycle start; returns just after the sampling edge
  task automatic do_start(input logic [3:0] th, input logic [3:0] hu,
                          input logic [3:0] te, input logic [3:0] on);
    thousands_i = th;
    hundreds_i  = hu;
    tens_i      = te;
    ones_i      = on;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int bcnt, output bit to);
    cycles = 0;
    bcnt   = 0;
    while (done_o !== 1'b1 && cycles < 20) begin
      if (busy_o === 1'b1) bcnt++;
      tick();
      cycles++;
    end
    to = (done_o !== 1'b1);
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({binary_o, busy_o, done_o, error_o} !== 19'd0) begin
      errors++;
      $display("FAIL reset_hold: got bin=%h busy=%b done=%b err=%b, want all 0",
               binary_o, busy_o, done_o, error_o);
    end
    rst_i = 1'b0;
    tick();
    tick();
    checks++;
    if ({binary_o, busy_o, done_o, error_o} !== 19'd0) begin
      errors++;
      $display("FAIL reset_idle: got bin=%h busy=%b done=%b err=%b, want all 0",
               binary_o, busy_o, done_o, error_o);
    end
  endtask

  task automatic test_max();
    int cyc, bc;
    bit to;
    do_start(4'd9, 4'd9, 4'd9, 4'd9);
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != 4) begin
      errors++;
      $display("FAIL max_latency: got %0d cycles (timeout=%0b), want 4", cyc, to);
    end
    checks++;
    if (bc != 4) begin
      errors++;
      $display("FAIL max_busy_len: got %0d busy cycles, want 4", bc);
    end
    checks++;
    if ({error_o, binary_o} !== {1'b0, 16'h270F}) begin
      errors++;
      $display("FAIL max_value: got err=%b bin=%h, want err=0 bin=270f", error_o, binary_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || binary_o !== 16'h270F) begin
      errors++;
      $display("FAIL max_after: got done=%b bin=%h, want done=0 bin=270f", done_o, binary_o);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    bit to;
    do_start(4'd0, 4'd0, 4'd0, 4'd0);
    wait_done(cyc, bc, to);
    checks++;
    if (to || {error_o, binary_o} !== 17'd0) begin
      errors++;
      $display("FAIL zero_value: got err=%b bin=%h timeout=%0b, want err=0 bin=0000",
               error_o, binary_o, to);
    end
    do_start(4'd1, 4'd2, 4'd3, 4'd4);
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc + 1 != 5) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between dones (timeout=%0b), want 5", cyc + 1, to);
    end
    checks++;
    if ({error_o, binary_o} !== {1'b0, 16'h04D2}) begin
      errors++;
      $display("FAIL b2b_value: got err=%b bin=%h, want err=0 bin=04d2", error_o, binary_o);
    end
  endtask

  task automatic test_invalid();
    int cyc, bc;
    bit to;
    tick();
    do_start(4'd0, 4'd5, 4'hA, 4'd1);
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != 4) begin
      errors++;
      $display("FAIL inv_latency: got %0d cycles (timeout=%0b), want 4", cyc, to);
    end
    checks++;
    if ({error_o, binary_o} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL inv_value: got err=%b bin=%h, want err=1 bin=0000", error_o, binary_o);
    end
    tick();
    do_start(4'd0, 4'd0, 4'd4, 4'd2);
    checks++;
    if ({error_o, binary_o} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL inv_held: got err=%b bin=%h, want err=1 bin=0000 until done", error_o, binary_o);
    end
    wait_done(cyc, bc, to);
    checks++;
    if (to || {error_o, binary_o} !== {1'b0, 16'h002A}) begin
      errors++;
      $display("FAIL inv_recover: got err=%b bin=%h timeout=%0b, want err=0 bin=002a",
               error_o, binary_o, to);
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    logic [15:0] seen;
    tick();
    do_start(4'd2, 4'd0, 4'd2, 4'd1);
    tick();
    do_start(4'd9, 4'd9, 4'd9, 4'd9);
    thousands_i = 4'd7;
    dones = 0;
    seen  = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      if (done_o === 1'b1) begin
        dones++;
        seen = binary_o;
      end
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ign_done_count: got %0d done pulses, want 1", dones);
    end
    checks++;
    if (seen !== 16'h07E5 || binary_o !== 16'h07E5) begin
      errors++;
      $display("FAIL ign_value: got bin=%h (at done %h), want 07e5", binary_o, seen);
    end
  endtask

  task automatic test_reset_mid();
    int dones, cyc, bc;
    bit to;
    do_start(4'd5, 4'd6, 4'd7, 4'd8);
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({binary_o, busy_o, done_o, error_o} !== 19'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: got bin=%h busy=%b done=%b err=%b, want all 0",
               binary_o, busy_o, done_o, error_o);
    end
    tick();
    #2 rst_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d cycles with done/busy after reset, want 0", dones);
    end
    do_start(4'd5, 4'd6, 4'd7, 4'd8);
    wait_done(cyc, bc, to);
    checks++;
    if (to || {error_o, binary_o} !== {1'b0, 16'h162E}) begin
      errors++;
      $display("FAIL rst_mid_restart: got err=%b bin=%h timeout=%0b, want err=0 bin=162e",
               error_o, binary_o, to);
    end
  endtask

  task automatic test_sweep();
    int cyc, bc;
    bit to;
    logic [15:0] exp;
    tick();
    for (int th = 0; th < 10; th++) begin
      for (int hu = 0; hu < 10; hu++) begin
        for (int te = 0; te < 10; te++) begin
          for (int on = 0; on < 10; on++) begin
            exp = 16'(th * 1000 + hu * 100 + te * 10 + on);
            do_start(4'(th), 4'(hu), 4'(te), 4'(on));
            wait_done(cyc, bc, to);
            checks++;
            if (to || {error_o, binary_o} !== {1'b0, exp}) begin
              errors++;
              $display("FAIL sweep_%0d%0d%0d%0d: got err=%b bin=%h timeout=%0b, want err=0 bin=%h",
                       th, hu, te, on, error_o, binary_o, to, exp);
              if (to) return;
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_invalid();
    test_ignored_start();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
